subservient_timer: RTL and testbench

- Wishbone-slave machine timer placed directly downstream of the CPU wrapper's external data bus (o_wb_* / i_wb_rdt / i_wb_ack).
- Produces the i_timer_irq input that the wrapper feeds to the core.
- Contains a prescaled 32-bit free-running counter (mtime), a 32-bit compare register (mtimecmp), a control register and a prescale register.
- The interrupt is level-type and asserts while mtime >= mtimecmp and the interrupt is enabled.

---
 rtl/subservient_timer_pkg.sv | 23 ++
 rtl/subservient_timer_presc.sv | 25 ++
 rtl/subservient_timer.sv | 100 ++++++++++
 tb/tb_subservient_timer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/subservient_timer_pkg.sv
// Shared register offsets, CTRL bit positions and byte-lane merge helper
// for the subservient machine timer.
package subservient_timer_pkg;

    localparam logic [1:0] TMR_MTIME = 2'd0;
    localparam logic [1:0] TMR_CMP   = 2'd1;
    localparam logic [1:0] TMR_CTRL  = 2'd2;
    localparam logic [1:0] TMR_PRESC = 2'd3;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;

    function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? wdat[8*i +: 8] : cur[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/subservient_timer_presc.sv
// Prescale counter: emits a one-cycle tick every (presc+1) enabled clocks.
module subservient_timer_presc (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic [15:0] i_presc,
    input  logic        i_clr,
    output logic        o_tick
);

    logic [15:0] pcnt;

    assign o_tick = i_en & (pcnt == i_presc);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pcnt <= 16'd0;
        end else if (i_clr) begin
            pcnt <= 16'd0;
        end else if (i_en) begin
            pcnt <= o_tick ? 16'd0 : pcnt + 16'd1;
        end
    end

endmodule

// File: rtl/subservient_timer.sv
// Wishbone-slave machine timer: mtime/mtimecmp/CTRL/PRESCALE registers
// and a registered level interrupt for the core.
module subservient_timer
    import subservient_timer_pkg::*;
#(
    parameter logic [15:0] RESET_PRESCALE = 16'd0,
    parameter logic [31:0] RESET_CMP      = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_timer_irq
);

    logic [31:0] mtime, mtimecmp;
    logic [1:0]  ctrl;
    logic [15:0] presc;

    logic [31:0] mtime_inc, mtime_nxt, cmp_nxt, rd_mux;
    logic [1:0]  ctrl_nxt;
    logic [15:0] presc_nxt;
    logic        presc_clr, tick, acc, wr, irq_nxt;
    logic [1:0]  adr;
    logic        unused_adr;

    assign adr        = i_wb_adr[3:2];
    assign unused_adr = ^{i_wb_adr[31:4], i_wb_adr[1:0], i_wb_dat[31:16]};

    // The ack flop is the whole bus FSM: an access is taken only while idle.
    assign acc = i_wb_stb & ~o_wb_ack;
    assign wr  = acc & i_wb_we;

    subservient_timer_presc u_presc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (ctrl[CTRL_EN]),
        .i_presc (presc),
        .i_clr   (presc_clr),
        .o_tick  (tick)
    );

    always_comb begin
        mtime_inc = tick ? mtime + 32'd1 : mtime;
        mtime_nxt = mtime_inc;
        cmp_nxt   = mtimecmp;
        ctrl_nxt  = ctrl;
        presc_nxt = presc;
        presc_clr = 1'b0;
        rd_mux    = 32'd0;
        // Bus bytes override the incremented count when both land on one edge.
        if (wr) begin
            case (adr)
                TMR_MTIME: mtime_nxt = byte_merge(mtime_inc, i_wb_dat, i_wb_sel);
                TMR_CMP:   cmp_nxt   = byte_merge(mtimecmp, i_wb_dat, i_wb_sel);
                TMR_CTRL:  if (i_wb_sel[0]) ctrl_nxt = i_wb_dat[1:0];
                TMR_PRESC: begin
                    presc_clr = 1'b1;
                    presc_nxt = {i_wb_sel[1] ? i_wb_dat[15:8] : presc[15:8],
                                 i_wb_sel[0] ? i_wb_dat[7:0]  : presc[7:0]};
                end
                default: ;
            endcase
        end
        case (adr)
            TMR_MTIME: rd_mux = mtime;
            TMR_CMP:   rd_mux = mtimecmp;
            TMR_CTRL:  rd_mux = {30'd0, ctrl};
            TMR_PRESC: rd_mux = {16'd0, presc};
            default:   rd_mux = 32'd0;
        endcase
        irq_nxt = ctrl_nxt[CTRL_IE] & (mtime_nxt >= cmp_nxt);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtime       <= 32'd0;
            mtimecmp    <= RESET_CMP;
            ctrl        <= 2'd0;
            presc       <= RESET_PRESCALE;
            o_wb_ack    <= 1'b0;
            o_wb_rdt    <= 32'd0;
            o_timer_irq <= 1'b0;
        end else begin
            mtime       <= mtime_nxt;
            mtimecmp    <= cmp_nxt;
            ctrl        <= ctrl_nxt;
            presc       <= presc_nxt;
            o_wb_ack    <= acc;
            o_wb_rdt    <= acc ? rd_mux : 32'd0;
            o_timer_irq <= irq_nxt;
        end
    end

endmodule

// File: tb/tb_subservient_timer.sv
// Directed bench for subservient_timer: register table plus timing sequences.
module tb_subservient_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] wb_adr = 32'd0;
    logic [31:0] wb_dat = 32'd0;
    logic [3:0]  wb_sel = 4'd0;
    logic        wb_we = 1'b0;
    logic        wb_stb = 1'b0;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic        timer_irq;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [1:0] A_MTIME = 2'd0;
    localparam logic [1:0] A_CMP   = 2'd1;
    localparam logic [1:0] A_CTRL  = 2'd2;
    localparam logic [1:0] A_PRESC = 2'd3;

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp_rdt;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[16];

    subservient_timer dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wb_adr    (wb_adr),
        .i_wb_dat    (wb_dat),
        .i_wb_sel    (wb_sel),
        .i_wb_we     (wb_we),
        .i_wb_stb    (wb_stb),
        .o_wb_rdt    (wb_rdt),
        .o_wb_ack    (wb_ack),
        .o_timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // One access; returns just after the ack edge with stb already released.
    task automatic bus(input logic we, input logic [1:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r);
        int n;
        n = 0;
        if (wb_ack) tick1();
        wb_adr = {28'h5A5A5A5, a, 2'b10};
        wb_dat = d;
        wb_sel = s;
        wb_we  = we;
        wb_stb = 1'b1;
        do begin
            tick1();
            n++;
        end while (!wb_ack && n < 8);
        r = wb_rdt;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        chk("ack_latency", n, 1);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus(1'b1, a, d, 4'hF, r);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] r);
        bus(1'b0, a, 32'd0, 4'hF, r);
    endtask

    initial begin
        logic [31:0] r;

        vecs[0]  = '{1'b0, A_CMP,   32'h0,         4'hF, 32'hFFFF_FFFF, 1'b0};
        vecs[1]  = '{1'b0, A_MTIME, 32'h0,         4'hF, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, A_CTRL,  32'h0,         4'hF, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, A_PRESC, 32'h0,         4'hF, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b1, A_MTIME, 32'h1122_3344, 4'hF, 32'h0,         1'b0};
        vecs[5]  = '{1'b0, A_MTIME, 32'h0,         4'hF, 32'h1122_3344, 1'b0};
        vecs[6]  = '{1'b1, A_MTIME, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0};
        vecs[7]  = '{1'b0, A_MTIME, 32'h0,         4'hF, 32'h11BB_33DD, 1'b0};
        vecs[8]  = '{1'b1, A_CTRL,  32'hFFFF_FFFC, 4'hF, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, A_CTRL,  32'h0,         4'hF, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b1, A_PRESC, 32'h1234_5678, 4'hF, 32'h0,         1'b0};
        vecs[11] = '{1'b0, A_PRESC, 32'h0,         4'hF, 32'h0000_5678, 1'b0};
        vecs[12] = '{1'b1, A_PRESC, 32'hAAAA_0000, 4'hC, 32'h0,         1'b0};
        vecs[13] = '{1'b0, A_PRESC, 32'h0,         4'hF, 32'h0000_5678, 1'b0};
        vecs[14] = '{1'b1, A_CMP,   32'hDEAD_BEEF, 4'hA, 32'h0,         1'b0};
        vecs[15] = '{1'b0, A_CMP,   32'h0,         4'hF, 32'hDEFF_BEFF, 1'b0};

        // Asynchronous reset asserted between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ack", 32'(wb_ack), 32'd0);
        chk("rst_rdt", wb_rdt, 32'd0);
        chk("rst_irq", 32'(timer_irq), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick1();

        // Register table with the counter disabled
        for (int i = 0; i < 16; i++) begin
            bus(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, r);
            if (!vecs[i].we) chk($sformatf("vec%0d_rdt", i), r, vecs[i].exp_rdt);
            chk($sformatf("vec%0d_irq", i), 32'(timer_irq), 32'(vecs[i].exp_irq));
            tick1();
            chk($sformatf("vec%0d_rdt_idle", i), wb_rdt, 32'd0);
        end

        // Counting with PRESCALE=3
        wr(A_MTIME, 32'd0);
        wr(A_PRESC, 32'd3);
        wr(A_CTRL, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        rd(A_MTIME, r);
        chk("count_40", r, 32'd10);
        wr(A_CTRL, 32'd0);

        // Interrupt rise at mtime==cmp, then clear by larger cmp and by IE=0
        wr(A_MTIME, 32'd0);
        wr(A_PRESC, 32'd0);
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'd3);
        chk("irq_after_en", 32'(timer_irq), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            tick1();
            chk($sformatf("irq_step%0d", k), 32'(timer_irq), (k >= 5) ? 32'd1 : 32'd0);
        end
        wr(A_CMP, 32'd100);
        chk("irq_cmp100", 32'(timer_irq), 32'd0);
        wr(A_CMP, 32'd0);
        chk("irq_cmp0", 32'(timer_irq), 32'd1);
        wr(A_CTRL, 32'd1);
        chk("irq_ie0", 32'(timer_irq), 32'd0);
        wr(A_CTRL, 32'd0);

        // Wrap through 32'hFFFF_FFFF
        wr(A_PRESC, 32'd0);
        wr(A_CMP, 32'hFFFF_FFFF);
        wr(A_MTIME, 32'hFFFF_FFFE);
        wr(A_CTRL, 32'd3);
        chk("wrap_irq0", 32'(timer_irq), 32'd0);
        tick1();
        chk("wrap_irq_max", 32'(timer_irq), 32'd1);
        tick1();
        chk("wrap_irq_zero", 32'(timer_irq), 32'd0);
        rd(A_MTIME, r);
        chk("wrap_mtime", r, 32'd0);
        wr(A_CTRL, 32'd0);

        // Bus write colliding with a tick (PRESCALE=1: ticks on even edges after EN)
        wr(A_MTIME, 32'h0000_0040);
        wr(A_PRESC, 32'd1);
        wr(A_CTRL, 32'd1);
        wr(A_MTIME, 32'd0);
        rd(A_MTIME, r);
        chk("collision_mtime", r, 32'd0);

        // stb held high for six cycles
        tick1();
        wb_adr = {28'h0, A_CTRL, 2'b00};
        wb_we  = 1'b0;
        wb_sel = 4'hF;
        wb_stb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("held_ack%0d", i), 32'(wb_ack), 32'(i % 2));
            chk($sformatf("held_rdt%0d", i), wb_rdt, 32'(i % 2));
            if (i < 5) tick1();
        end
        wb_stb = 1'b0;

        // Reset asserted mid-transaction while the interrupt is active
        wr(A_CMP, 32'd0);
        wr(A_CTRL, 32'd3);
        tick1();
        wb_adr = {28'h0, A_PRESC, 2'b00};
        wb_stb = 1'b1;
        tick1();
        chk("pre_rst_ack", 32'(wb_ack), 32'd1);
        chk("pre_rst_irq", 32'(timer_irq), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(wb_ack), 32'd0);
        chk("mid_rst_rdt", wb_rdt, 32'd0);
        chk("mid_rst_irq", 32'(timer_irq), 32'd0);
        wb_stb = 1'b0;
        #2 rst_n = 1'b1;
        tick1();
        rd(A_CMP, r);
        chk("post_rst_cmp", r, 32'hFFFF_FFFF);
        rd(A_CTRL, r);
        chk("post_rst_ctrl", r, 32'd0);
        rd(A_MTIME, r);
        chk("post_rst_mtime", r, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
